// File: rtl/esc_multi_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : esc_multi_pwm
//  Purpose  : N-channel ESC drive block. Per-channel speed/offset shadow
//             setpoints (inc pulses or direct load), committed to the active
//             set at each PWM period boundary; one registered PWM per ESC.
//  Revision : 1.0  initial release
// ============================================================================
module esc_multi_pwm #(
   parameter int NCH      = 4,
   parameter int SPD_W    = 11,
   parameter int OFF_W    = 10,
   parameter int PER_W    = 20,
   parameter int BASE     = 6250,
   parameter int MULT     = 3,
   parameter int STEP     = 16,
   parameter int SAT_MODE = 1,
   localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             sel_speed,
   input  logic [CH_W-1:0]  ch_sel,
   input  logic             ld,
   input  logic [CH_W-1:0]  ld_ch,
   input  logic [SPD_W-1:0] ld_speed,
   input  logic [OFF_W-1:0] ld_off,
   output logic [SPD_W-1:0] SPEED,
   output logic [OFF_W-1:0] OFF,
   output logic             period_st,
   output logic [NCH-1:0]   PWM
);

   localparam logic [PER_W-1:0] c_cnt_max = '1;

   logic [PER_W-1:0] cnt_q, cnt_d;
   logic [SPD_W-1:0] shd_spd_q [NCH];
   logic [SPD_W-1:0] shd_spd_d [NCH];
   logic [OFF_W-1:0] shd_off_q [NCH];
   logic [OFF_W-1:0] shd_off_d [NCH];
   logic [SPD_W-1:0] act_spd_q [NCH];
   logic [SPD_W-1:0] act_spd_d [NCH];
   logic [OFF_W-1:0] act_off_q [NCH];
   logic [OFF_W-1:0] act_off_d [NCH];
   logic [NCH-1:0]   pwm_q, pwm_d;

   logic [SPD_W-1:0] w_spd_inc [NCH];
   logic [OFF_W-1:0] w_off_inc [NCH];
   logic             w_wrap;

   assign w_wrap = (cnt_q == c_cnt_max);

   // Per-channel incremented values and pulse-width comparison
   generate
      for (genvar i = 0; i < NCH; i++) begin : g_ch
         logic [SPD_W:0]   w_spd_sum;
         logic [OFF_W:0]   w_off_sum;
         logic [SPD_W:0]   w_act_sum;
         logic [SPD_W-1:0] w_comp;
         logic [PER_W-1:0] w_width;

         assign w_spd_sum    = {1'b0, shd_spd_q[i]} + (SPD_W+1)'(STEP);
         assign w_off_sum    = {1'b0, shd_off_q[i]} + (OFF_W+1)'(STEP);
         assign w_spd_inc[i] = ((SAT_MODE != 0) && w_spd_sum[SPD_W]) ? '1 : w_spd_sum[SPD_W-1:0];
         assign w_off_inc[i] = ((SAT_MODE != 0) && w_off_sum[OFF_W]) ? '1 : w_off_sum[OFF_W-1:0];

         // Compensated speed is clamped to the speed field range before scaling
         assign w_act_sum = {1'b0, act_spd_q[i]} + (SPD_W+1)'(act_off_q[i]);
         assign w_comp    = w_act_sum[SPD_W] ? '1 : w_act_sum[SPD_W-1:0];
         assign w_width   = PER_W'(BASE) + PER_W'(MULT) * PER_W'(w_comp);
         assign pwm_d[i]  = (cnt_q < w_width);
      end
   endgenerate

   // Shadow update: load beats increment on the same channel; out-of-range targets match nothing
   always_comb begin
      shd_spd_d = shd_spd_q;
      shd_off_d = shd_off_q;
      for (int i = 0; i < NCH; i++) begin
         if (ld && (ld_ch == CH_W'(i))) begin
            shd_spd_d[i] = ld_speed;
            shd_off_d[i] = ld_off;
         end else if (inc && (ch_sel == CH_W'(i))) begin
            if (sel_speed) shd_spd_d[i] = w_spd_inc[i];
            else           shd_off_d[i] = w_off_inc[i];
         end
      end
   end

   // Commit shadow into active on the edge the counter wraps, so the whole period sees one value
   always_comb begin
      cnt_d = cnt_q + PER_W'(1);
      if (w_wrap) begin
         act_spd_d = shd_spd_q;
         act_off_d = shd_off_q;
      end else begin
         act_spd_d = act_spd_q;
         act_off_d = act_off_q;
      end
   end

   // Readback of the selected channel's shadow setpoints (0 when out of range)
   always_comb begin
      SPEED = '0;
      OFF   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch_sel == CH_W'(i)) begin
            SPEED = shd_spd_q[i];
            OFF   = shd_off_q[i];
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         shd_spd_q <= '{default: '0};
         shd_off_q <= '{default: '0};
         act_spd_q <= '{default: '0};
         act_off_q <= '{default: '0};
         pwm_q     <= '0;
      end else begin
         cnt_q     <= cnt_d;
         shd_spd_q <= shd_spd_d;
         shd_off_q <= shd_off_d;
         act_spd_q <= act_spd_d;
         act_off_q <= act_off_d;
         pwm_q     <= pwm_d;
      end
   end

   assign period_st = ~rst & (cnt_q == '0);
   assign PWM       = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_esc_multi_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_esc_multi_pwm
//  Purpose  : Self-checking bench for esc_multi_pwm. Two instances share the
//             stimulus: A (4 ch, saturating) and B (3 ch, wrapping), both with
//             a short period so several full periods fit in the run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_esc_multi_pwm;

   localparam int P_W  = 14;
   localparam int P    = 1 << P_W;
   localparam int CMAX = 2047;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inc = 1'b0, sel_speed = 1'b0, ld = 1'b0;
   logic [1:0]  ch_sel = '0, ld_ch = '0;
   logic [10:0] ld_speed = '0;
   logic [9:0]  ld_off = '0;
   logic [10:0] spd_a, spd_b;
   logic [9:0]  off_a, off_b;
   logic        pst_a, pst_b;
   logic [3:0]  pwm_a;
   logic [2:0]  pwm_b;

   int tests = 0, fails = 0;
   bit started = 0;

   always #5 clk = ~clk;

   esc_multi_pwm #(.NCH(4), .PER_W(P_W), .SAT_MODE(1)) dut_a (
      .clk(clk), .rst(rst), .inc(inc), .sel_speed(sel_speed), .ch_sel(ch_sel),
      .ld(ld), .ld_ch(ld_ch), .ld_speed(ld_speed), .ld_off(ld_off),
      .SPEED(spd_a), .OFF(off_a), .period_st(pst_a), .PWM(pwm_a));

   esc_multi_pwm #(.NCH(3), .PER_W(P_W), .SAT_MODE(0)) dut_b (
      .clk(clk), .rst(rst), .inc(inc), .sel_speed(sel_speed), .ch_sel(ch_sel),
      .ld(ld), .ld_ch(ld_ch), .ld_speed(ld_speed), .ld_off(ld_off),
      .SPEED(spd_b), .OFF(off_b), .period_st(pst_b), .PWM(pwm_b));

   // ---------------- behavioural model ----------------
   int sh_spd [2][4] = '{default: 0};
   int sh_off [2][4] = '{default: 0};
   int ac_spd [2][4] = '{default: 0};
   int ac_off [2][4] = '{default: 0};
   int cnt_m  [2]    = '{default: 0};
   logic [3:0] pwm_m [2] = '{default: '0};
   int hc     [2][4] = '{default: 0};
   int pw_exp [2][4] = '{default: 0};
   int last   [2][4] = '{default: 0};
   bit valid  [2]    = '{default: 0};

   function automatic int nch_of(int k);
      return (k == 0) ? 4 : 3;
   endfunction

   function automatic int width_of(int s, int o);
      int c = s + o;
      if (c > CMAX) c = CMAX;
      return 6250 + 3 * c;
   endfunction

   function automatic int bump(int v, int w, bit sat);
      int lim = 1 << w;
      v = v + 16;
      if (v >= lim) v = sat ? lim - 1 : v - lim;
      return v;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int c = 0; c < 4; c++) begin
               sh_spd[k][c] = 0; sh_off[k][c] = 0; ac_spd[k][c] = 0; ac_off[k][c] = 0;
            end
            cnt_m[k] = 0;
            pwm_m[k] = '0;
         end else begin
            bit ldv, incv;
            for (int c = 0; c < nch_of(k); c++)
               pwm_m[k][c] = (cnt_m[k] < width_of(ac_spd[k][c], ac_off[k][c]));
            if (cnt_m[k] == P - 1)
               for (int c = 0; c < 4; c++) begin
                  ac_spd[k][c] = sh_spd[k][c]; ac_off[k][c] = sh_off[k][c];
               end
            ldv  = ld && (int'(ld_ch) < nch_of(k));
            incv = inc && (int'(ch_sel) < nch_of(k)) && !(ldv && ld_ch == ch_sel);
            if (ldv) begin
               sh_spd[k][ld_ch] = ld_speed;
               sh_off[k][ld_ch] = ld_off;
            end
            if (incv) begin
               if (sel_speed) sh_spd[k][ch_sel] = bump(sh_spd[k][ch_sel], 11, k == 0);
               else           sh_off[k][ch_sel] = bump(sh_off[k][ch_sel], 10, k == 0);
            end
            cnt_m[k] = (cnt_m[k] + 1) % P;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- per-cycle compare + per-period high-time measurement ----------------
   always @(posedge clk) begin
      #1;
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            logic [10:0] s_dut;
            logic [9:0]  o_dut;
            logic        p_dut;
            logic [3:0]  w_dut;
            int          es, eo;
            bit          epst;
            s_dut = (k == 0) ? spd_a : spd_b;
            o_dut = (k == 0) ? off_a : off_b;
            p_dut = (k == 0) ? pst_a : pst_b;
            w_dut = (k == 0) ? pwm_a : {1'b0, pwm_b};
            es    = (int'(ch_sel) < nch_of(k)) ? sh_spd[k][ch_sel] : 0;
            eo    = (int'(ch_sel) < nch_of(k)) ? sh_off[k][ch_sel] : 0;
            epst  = !rst && (cnt_m[k] == 0);
            check($sformatf("speed_rb%0d", k), 32'(s_dut), es);
            check($sformatf("off_rb%0d", k), 32'(o_dut), eo);
            check($sformatf("period_st%0d", k), 32'(p_dut), 32'(epst));
            check($sformatf("pwm%0d", k), 32'(w_dut), 32'(pwm_m[k]));
            for (int c = 0; c < nch_of(k); c++) begin
               if (rst) begin
                  hc[k][c] = 0;
               end else begin
                  if (epst) begin
                     if (valid[k]) check($sformatf("high_time%0d_ch%0d", k, c), hc[k][c], pw_exp[k][c]);
                     last[k][c]   = hc[k][c];
                     hc[k][c]     = 0;
                     pw_exp[k][c] = width_of(ac_spd[k][c], ac_off[k][c]);
                  end
                  if (w_dut[c] === 1'b1) hc[k][c]++;
               end
            end
            if (rst) valid[k] = 0;
            else if (epst) valid[k] = 1;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pst();
      int g = 0;
      while (pst_a !== 1'b1 && g < 20000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 20000) check("period_st_timeout", 32'(g), 0);
   endtask

   task automatic strobe_inc(input logic [1:0] ch, input logic spd);
      ch_sel = ch; sel_speed = spd; inc = 1'b1;
      tick(1);
      inc = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      started = 1;
      tick(3);
      check("reset_pwm", 32'(pwm_a), 0);
      check("reset_pst", 32'(pst_a), 0);
      check("reset_speed", 32'(spd_a), 0);
      rst = 1'b0;
      tick(10);
      check("idle_pwm_high", 32'(pwm_a), 32'hF);

      // four speed increments on channel 1
      for (int i = 0; i < 4; i++) begin
         strobe_inc(2'd1, 1'b1);
         tick(1);
      end
      check("inc4_speed_a", 32'(spd_a), 64);
      check("inc4_speed_b", 32'(spd_b), 64);

      // load + inc on the same channel: load wins (B has no channel 3)
      ch_sel = 2'd3; sel_speed = 1'b1; inc = 1'b1;
      ld = 1'b1; ld_ch = 2'd3; ld_speed = 11'd500; ld_off = 10'd0;
      tick(1);
      ld = 1'b0; inc = 1'b0;
      check("ld_wins_a", 32'(spd_a), 500);
      check("out_of_range_b", 32'(spd_b), 0);

      // load ch0 + inc ch1 in the same cycle: both apply
      ch_sel = 2'd1; inc = 1'b1; ld = 1'b1; ld_ch = 2'd0; ld_speed = 11'd100;
      tick(1);
      ld = 1'b0; inc = 1'b0;
      check("both_inc_ch1", 32'(spd_a), 80);
      ch_sel = 2'd0;
      tick(1);
      check("both_ld_ch0", 32'(spd_a), 100);

      // saturate vs wrap on channel 2
      ld = 1'b1; ld_ch = 2'd2; ld_speed = 11'd2040; ld_off = 10'd0;
      tick(1);
      ld = 1'b0;
      strobe_inc(2'd2, 1'b1);
      check("sat_speed_a", 32'(spd_a), 2047);
      check("wrap_speed_b", 32'(spd_b), 8);

      // channel 1 back to 64 for the commit check; channel 0 clamped compensation
      ld = 1'b1; ld_ch = 2'd1; ld_speed = 11'd64; ld_off = 10'd0;
      tick(1);
      ld_ch = 2'd0; ld_speed = 11'd2000; ld_off = 10'd100;
      tick(1);
      ld = 1'b0; ch_sel = 2'd0;
      tick(1);
      check("ld_off_ch0", 32'(off_a), 100);

      // offset increment on channel 3
      strobe_inc(2'd3, 1'b0);
      check("inc_off_a", 32'(off_a), 16);
      check("inc_off_b", 32'(off_b), 0);

      // end of period 0: old widths held all period
      wait_pst();
      for (int c = 0; c < 4; c++) check($sformatf("p0_width_ch%0d", c), last[0][c], 6250);
      // write in the commit cycle must only take effect one period later
      ld = 1'b1; ld_ch = 2'd1; ld_speed = 11'd0; ld_off = 10'd0;
      tick(1);
      ld = 1'b0;

      wait_pst();
      check("p1_width_ch0", last[0][0], 12391);
      check("p1_width_ch1", last[0][1], 6442);
      check("p1_width_ch2", last[0][2], 12391);
      check("p1_width_ch3", last[0][3], 7798);
      check("p1_width_b_ch2", last[1][2], 6274);

      // reset mid-pulse
      tick(100);
      check("mid_pulse_high", 32'(pwm_a), 32'hF);
      rst = 1'b1;
      tick(1);
      check("reset_drops_pwm", 32'(pwm_a), 0);
      tick(2);
      rst = 1'b0;
      #1;
      check("restart_pst", 32'(pst_a), 1);
      tick(1);
      check("restart_speed_cleared", 32'(spd_a), 0);
      wait_pst();
      for (int c = 0; c < 4; c++) check($sformatf("post_rst_width_ch%0d", c), last[0][c], 6250);
      tick(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
